// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: result bus of the period meter.
//
// Handshake: meas_valid is a one-cycle strobe that marks the cycle in which
// meas_period/overflow take a new value. There is no ready; the producer never
// waits, and a consumer that misses a strobe reads the held meas_period.
// state_dbg mirrors the FSM (0 = WAIT_EDGE, 1 = MEASURE) for observation.
interface clk_period_meter_if #(
    parameter int CNT_W = 24
);
    logic             sig_in;
    logic [CNT_W-1:0] meas_period;
    logic             meas_valid;
    logic             overflow;
    logic             state_dbg;

    // The meter drives results and consumes the raw input.
    modport master (
        input  sig_in,
        output meas_period,
        output meas_valid,
        output overflow,
        output state_dbg
    );

    // The environment drives the raw input and consumes results.
    modport slave (
        output sig_in,
        input  meas_period,
        input  meas_valid,
        input  overflow,
        input  state_dbg
    );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous square wave
// in clkin cycles. Each completed period yields a registered result with a
// one-cycle strobe; a stalled input saturates the counter and is reported as
// an all-ones overflow result.
//
// Optional feature: define CLK_METER_AVG_EN to report the truncated average
// of every 4 consecutive periods instead of each period individually.
module clk_period_meter #(
    parameter int IN_CLK_FRQ = 1000000,
    parameter int CNT_W      = 24
) (
    input logic                reset,
    input logic                clkin,
    clk_period_meter_if.master bus
);

    if (CNT_W < 4 || CNT_W > 32 || IN_CLK_FRQ <= 0) begin : g_bad_param
        $error("clk_period_meter: CNT_W must be 4..32 and IN_CLK_FRQ positive");
    end

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             period_done;
    logic             timeout;
    logic             report;
    logic [CNT_W-1:0] report_val;

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // FSM state and period counter registers.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state <= WAIT_EDGE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next state and counter; saturation wins over a coincident rise.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        period_done = 1'b0;
        timeout     = 1'b0;
        case (state)
            WAIT_EDGE: begin
                if (rise) begin
                    count_nxt = CNT_ONE;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (count == CNT_MAX) begin
                    timeout   = 1'b1;
                    state_nxt = WAIT_EDGE;
                end else if (rise) begin
                    period_done = 1'b1;
                    count_nxt   = CNT_ONE;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            default: begin
                state_nxt = WAIT_EDGE;
            end
        endcase
    end

`ifdef CLK_METER_AVG_EN
    logic [CNT_W+1:0] acc;
    logic [CNT_W+1:0] acc_sum;
    logic [1:0]       grp;

    assign acc_sum    = acc + {2'b00, count};
    assign report     = period_done && (grp == 2'd3);
    assign report_val = acc_sum[CNT_W+1:2];

    // Accumulate groups of four periods; a timeout restarts the group.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            acc <= '0;
            grp <= 2'd0;
        end else if (timeout) begin
            acc <= '0;
            grp <= 2'd0;
        end else if (period_done) begin
            if (grp == 2'd3) begin
                acc <= '0;
                grp <= 2'd0;
            end else begin
                acc <= acc_sum;
                grp <= grp + 2'd1;
            end
        end
    end
`else
    assign report     = period_done;
    assign report_val = count;
`endif

    // Result registers: held between updates, strobe lasts one cycle.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            bus.meas_period <= '0;
            bus.meas_valid  <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.meas_valid <= 1'b0;
            if (timeout) begin
                bus.meas_period <= CNT_MAX;
                bus.meas_valid  <= 1'b1;
                bus.overflow    <= 1'b1;
            end else if (report) begin
                bus.meas_period <= report_val;
                bus.meas_valid  <= 1'b1;
                bus.overflow    <= 1'b0;
            end
        end
    end

    assign bus.state_dbg = (state == MEASURE);

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed bench for clk_period_meter with CNT_W = 8.
// sig_in is driven on falling clkin edges, so every period is exact and
// strobe timing is predictable. Build with CLK_METER_AVG_EN to cover averaging.
module tb_clk_period_meter;
    localparam int CNT_W = 8;
    localparam int SAT   = 255;
`ifdef CLK_METER_AVG_EN
    localparam int GRP = 4;
`else
    localparam int GRP = 1;
`endif

    typedef struct {
        int hi;
        int lo;
        int rises;
        int exp_period;
    } vec_t;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   failures = 0;

    int got_val_q[$];
    int got_ovf_q[$];
    int got_cyc_q[$];
    logic [CNT_W-1:0] exp_q[$];

    clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

    clk_period_meter #(
        .IN_CLK_FRQ(1000000),
        .CNT_W     (CNT_W)
    ) dut (
        .reset(reset),
        .clkin(clkin),
        .bus  (bus)
    );

    // Clock and cycle counter.
    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    // Strobe collector, sampled on the falling edge.
    always @(negedge clkin) begin
        if (bus.meas_valid === 1'b1) begin
            got_val_q.push_back(int'(bus.meas_period));
            got_ovf_q.push_back(int'(bus.overflow));
            got_cyc_q.push_back(cyc);
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_q();
        got_val_q.delete();
        got_ovf_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic do_reset();
        bus.sig_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clkin);
        reset = 1'b0;
        repeat (3) @(negedge clkin);
        clear_q();
    endtask

    // One rising edge followed by hi high cycles and lo low cycles.
    task automatic drive_rise(input int hi, input int lo);
        bus.sig_in = 1'b1;
        repeat (hi) @(negedge clkin);
        bus.sig_in = 1'b0;
        repeat (lo) @(negedge clkin);
    endtask

    task automatic check_strobes(input string name, input int exp_n, input int exp_val,
                                 input int exp_ovf, input int exp_gap);
        check({name, " strobe count"}, got_val_q.size(), exp_n);
        for (int i = 0; i < got_val_q.size() && i < exp_n; i++) begin
            check({name, " period"}, got_val_q[i], exp_val);
            check({name, " overflow"}, got_ovf_q[i], exp_ovf);
            if (i > 0 && exp_gap > 0)
                check({name, " strobe gap"}, got_cyc_q[i] - got_cyc_q[i-1], exp_gap);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   c0;

        vecs[0] = '{hi: 5,  lo: 5,  rises: 9, exp_period: 10};
        vecs[1] = '{hi: 2,  lo: 2,  rises: 9, exp_period: 4};
        vecs[2] = '{hi: 10, lo: 10, rises: 5, exp_period: 20};
        vecs[3] = '{hi: 3,  lo: 7,  rises: 9, exp_period: 10};
        vecs[4] = '{hi: 6,  lo: 2,  rises: 9, exp_period: 8};
        vecs[5] = '{hi: 4,  lo: 3,  rises: 9, exp_period: 7};

        bus.sig_in = 1'b0;
        reset = 1'b1;
        @(negedge clkin);
        check("reset meas_period", int'(bus.meas_period), 0);
        check("reset meas_valid", int'(bus.meas_valid), 0);
        check("reset overflow", int'(bus.overflow), 0);
        check("reset state", int'(bus.state_dbg), 0);

        // Regular square waves.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            repeat (vecs[v].rises) drive_rise(vecs[v].hi, vecs[v].lo);
            repeat (6) @(negedge clkin);
            check_strobes($sformatf("vec%0d", v), (vecs[v].rises - 1) / GRP,
                          vecs[v].exp_period, 0, vecs[v].exp_period * GRP);
        end

        // Irregular periods 10, 12, 10, 13.
        do_reset();
        drive_rise(5, 5);
        drive_rise(5, 7);
        drive_rise(5, 5);
        drive_rise(5, 8);
        drive_rise(2, 5);
        repeat (6) @(negedge clkin);
`ifdef CLK_METER_AVG_EN
        exp_q = '{8'd11};
`else
        exp_q = '{8'd10, 8'd12, 8'd10, 8'd13};
`endif
        check("mixed strobe count", got_val_q.size(), exp_q.size());
        for (int i = 0; i < got_val_q.size() && i < exp_q.size(); i++)
            check("mixed period", got_val_q[i], int'(exp_q[i]));

        // Stalled input: one rise, then held low until saturation.
        do_reset();
        c0 = cyc;
        bus.sig_in = 1'b1;
        repeat (2) @(negedge clkin);
        bus.sig_in = 1'b0;
        repeat (265) @(negedge clkin);
        check_strobes("timeout", 1, SAT, 1, 0);
        if (got_cyc_q.size() > 0)
            check("timeout latency", got_cyc_q[0] - c0, 258);
        check("timeout held period", int'(bus.meas_period), SAT);
        check("timeout state", int'(bus.state_dbg), 0);

        // Period-20 wave resumes; overflow stays set until a real result.
        clear_q();
        drive_rise(10, 10);
        check("sticky overflow", int'(bus.overflow), 1);
        repeat (GRP) drive_rise(10, 10);
        repeat (6) @(negedge clkin);
        check_strobes("resume", 1, 20, 0, 0);
        check("resume overflow level", int'(bus.overflow), 0);

        // Rise landing on the saturation cycle.
        do_reset();
        c0 = cyc;
        bus.sig_in = 1'b1;
        repeat (2) @(negedge clkin);
        bus.sig_in = 1'b0;
        repeat (253) @(negedge clkin);
        bus.sig_in = 1'b1;
        repeat (2) @(negedge clkin);
        bus.sig_in = 1'b0;
        repeat (8) @(negedge clkin);
        check_strobes("coincide", 1, SAT, 1, 0);
        if (got_cyc_q.size() > 0)
            check("coincide latency", got_cyc_q[0] - c0, 258);
        check("coincide state", int'(bus.state_dbg), 0);
        clear_q();
        repeat (GRP + 1) drive_rise(5, 5);
        repeat (6) @(negedge clkin);
        check_strobes("after coincide", 1, 10, 0, 0);

        // Asynchronous reset between edges, mid-period.
        do_reset();
        repeat (5) drive_rise(5, 5);
        check("pre-reset period", int'(bus.meas_period), 10);
        bus.sig_in = 1'b1;
        @(negedge clkin);
        #2;
        reset = 1'b1;
        #1;
        check("async reset meas_period", int'(bus.meas_period), 0);
        check("async reset meas_valid", int'(bus.meas_valid), 0);
        check("async reset overflow", int'(bus.overflow), 0);
        check("async reset state", int'(bus.state_dbg), 0);
        bus.sig_in = 1'b0;
        repeat (2) @(negedge clkin);
        reset = 1'b0;
        repeat (3) @(negedge clkin);
        clear_q();
        repeat (GRP + 1) drive_rise(5, 5);
        repeat (6) @(negedge clkin);
        check_strobes("post reset", 1, 10, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
